// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, active-video and strobe outputs.
// Decodes are taken from the next counter values so every output describes the (hcnt,vcnt) presented alongside it.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          pix_tick_q, pix_tick_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic          advance;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;

  always_comb begin
    advance = en && (div_q == DIV_LAST);
    h_next  = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
    v_next  = vcnt_q;
    if (hcnt_q == H_LAST) begin
      v_next = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end

    div_d         = div_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    pix_tick_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en) begin
      div_d = advance ? '0 : div_q + 1'b1;
    end

    // vsync looks at the line number only, so it changes together with the hcnt wrap
    if (advance) begin
      hcnt_d        = h_next;
      vcnt_d        = v_next;
      hsync_d       = (int'(h_next) >= H_ACTIVE + H_FP &&
                       int'(h_next) <  H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = (int'(v_next) >= V_ACTIVE + V_FP &&
                       int'(v_next) <  V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      active_d      = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
      pix_tick_d    = 1'b1;
      line_start_d  = (h_next == '0);
      frame_start_d = (h_next == '0) && (v_next == '0);
    end
  end

  // Reset parks on the last back-porch pixel so the first advance lands on (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      hcnt_q        <= H_LAST;
      vcnt_q        <= V_LAST;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      active_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small, divided, positive-hsync instance,
// both compared every cycle against a frame-position model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
    int cdiv;
  } cfg_t;

  typedef struct {
    int pos;
    int phase;
    bit hs, vs, act, pt, ls, fs;
  } mdl_t;

  logic clk;
  logic en_a, rst_a, en_b, rst_b;

  logic [9:0] hcnt_a, vcnt_a;
  logic       hs_a, vs_a, act_a, pt_a, ls_a, fs_a;
  logic [3:0] hcnt_b, vcnt_b;
  logic       hs_b, vs_b, act_b, pt_b, ls_b, fs_b;

  int   n_compared;
  int   n_mismatched;
  int   cyc;
  cfg_t cfg_a, cfg_b;
  mdl_t mdl_a, mdl_b;
  int   fs_times[$];

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .en(en_a),
    .hcnt(hcnt_a), .vcnt(vcnt_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .pix_tick(pt_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(4), .CW(4)
  ) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b),
    .hcnt(hcnt_b), .vcnt(vcnt_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .pix_tick(pt_b), .line_start(ls_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model tracks the linear pixel index within a frame plus the divider phase.
  function automatic mdl_t modelStep(mdl_t m, cfg_t c, bit en, bit rst);
    mdl_t n;
    int   ht, vt, h, v;
    n  = m;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    n.pt = 1'b0;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (rst) begin
      n.pos   = ht * vt - 1;
      n.phase = 0;
      n.hs    = !c.hp;
      n.vs    = !c.vp;
      n.act   = 1'b0;
    end else if (en) begin
      if (m.phase == c.cdiv - 1) begin
        n.phase = 0;
        n.pos   = (m.pos + 1) % (ht * vt);
        h       = n.pos % ht;
        v       = n.pos / ht;
        n.hs    = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
        n.vs    = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
        n.act   = (h < c.ha) && (v < c.va);
        n.pt    = 1'b1;
        n.ls    = (h == 0);
        n.fs    = (n.pos == 0);
      end else begin
        n.phase = m.phase + 1;
      end
    end
    return n;
  endfunction

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput(input string pfx, input mdl_t m, input cfg_t c,
                             input logic [31:0] h, input logic [31:0] v,
                             input logic hs, input logic vs, input logic act,
                             input logic pt, input logic ls, input logic fs);
    int ht;
    ht = c.ha + c.hf + c.hs + c.hb;
    checkField({pfx, "_hcnt"},        h,          32'(m.pos % ht));
    checkField({pfx, "_vcnt"},        v,          32'(m.pos / ht));
    checkField({pfx, "_hsync"},       32'(hs),    32'(m.hs));
    checkField({pfx, "_vsync"},       32'(vs),    32'(m.vs));
    checkField({pfx, "_active"},      32'(act),   32'(m.act));
    checkField({pfx, "_pix_tick"},    32'(pt),    32'(m.pt));
    checkField({pfx, "_line_start"},  32'(ls),    32'(m.ls));
    checkField({pfx, "_frame_start"}, 32'(fs),    32'(m.fs));
  endtask

  // One clock: drive inputs at the falling edge, advance models on the rising edge, check at the next falling edge.
  task automatic applyStimulus(input bit ea, input bit ra, input bit eb, input bit rb);
    en_a  = ea;
    rst_a = ra;
    en_b  = eb;
    rst_b = rb;
    @(posedge clk);
    cyc++;
    mdl_a = modelStep(mdl_a, cfg_a, ea, ra);
    mdl_b = modelStep(mdl_b, cfg_b, eb, rb);
    @(negedge clk);
    checkOutput("a", mdl_a, cfg_a, 32'(hcnt_a), 32'(vcnt_a), hs_a, vs_a, act_a, pt_a, ls_a, fs_a);
    checkOutput("b", mdl_b, cfg_b, 32'(hcnt_b), 32'(vcnt_b), hs_b, vs_b, act_b, pt_b, ls_b, fs_b);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    cfg_a = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
              hp: 1'b0, vp: 1'b0, cdiv: 1};
    cfg_b = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1,
              hp: 1'b1, vp: 1'b0, cdiv: 4};
    mdl_a = '{pos: 0, phase: 0, hs: 1'b0, vs: 1'b0, act: 1'b0, pt: 1'b0, ls: 1'b0, fs: 1'b0};
    mdl_b = mdl_a;
    en_a  = 1'b0;
    rst_a = 1'b1;
    en_b  = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);

    $display("[TB] reset, then reset held with en high");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    $display("[TB] release: two full default lines plus hsync window");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkField("a_first_hcnt",  32'(hcnt_a), 32'd0);
    checkField("a_first_frame", 32'(fs_a),   32'd1);
    for (int i = 0; i < 1700; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] frame_start period on divided instance");
    fs_times.delete();
    for (int i = 0; i < 1300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      if (fs_b === 1'b1) fs_times.push_back(cyc);
    end
    checkField("b_fs_seen", 32'(fs_times.size() >= 2), 32'd1);
    if (fs_times.size() >= 2) checkField("b_fs_period", 32'(fs_times[1] - fs_times[0]), 32'd600);

    $display("[TB] randomized enable and reset");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 499) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("[TB] enable low for 10 clocks");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-line on default instance");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 301; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkField("a_pre_reset_hcnt", 32'(hcnt_a), 32'd300);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkField("a_reset_hcnt", 32'(hcnt_a), 32'd799);
    checkField("a_reset_vcnt", 32'(vcnt_a), 32'd524);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
